// File: rtl/absval_pkg.sv
// ---------------------------------------------------------------------------
// absval_pkg
// Shared definitions for the absolute-value datapath and its consumers.
//   N_DEF / M_DEF : default sample width and requester count
//   ABS_MAX_W     : widest sample abs_sat can process
//   abs_sat()     : saturating two's-complement magnitude, returns {sat, mag}
// ---------------------------------------------------------------------------
package absval_pkg;

    localparam int N_DEF     = 8;
    localparam int M_DEF     = 4;
    localparam int ABS_MAX_W = 32;

    // The sample is passed sign-extended to ABS_MAX_W bits together with its
    // true width w, so one function serves every instance width. The caller
    // keeps the low w bits of the magnitude; bit ABS_MAX_W is the sat flag.
    // The most negative value has no positive counterpart in w bits and is
    // clamped to the largest positive value.
    function automatic logic [ABS_MAX_W:0] abs_sat(
        input logic signed [ABS_MAX_W-1:0] x,
        input int unsigned                 w
    );
        logic signed [ABS_MAX_W-1:0] minv;
        minv = {ABS_MAX_W{1'b1}} << (w - 1);
        if (x == minv) begin
            abs_sat = {1'b1, ~minv};
        end else if (x[ABS_MAX_W-1]) begin
            abs_sat = {1'b0, -x};
        end else begin
            abs_sat = {1'b0, x};
        end
    endfunction

endpackage

// File: rtl/absval_rr_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans req starting at ptr and wrapping
// modulo M; the first set bit wins.
//   req   in  M    request vector
//   ptr   in  IDW  index with highest priority this cycle (must be < M)
//   grant out M    one-hot winner, zero when no request
//   idx   out IDW  encoded winner, zero when no request
//   any   out 1    at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int M   = 4,
    localparam int IDW = $clog2(M)
) (
    input  logic [M-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [M-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int   j;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < M; k++) begin
            // ptr < M and k < M, so a single subtraction suffices for the
            // wrap, which also covers non-power-of-two M.
            j = int'(ptr) + k;
            if (j >= M) begin
                j = j - M;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
        any = found;
    end

endmodule

// File: rtl/absval_rr_arb.sv
// ---------------------------------------------------------------------------
// absval_rr_arb
// Shares one saturating absolute-value unit among M requesters with a
// round-robin grant and a single tagged output register.
//   clk        in  1     clock
//   rst        in  1     asynchronous active-high reset
//   req_valid  in  M     per-requester valid
//   req_data   in  M*N   signed sample of requester i at [i*N +: N]
//   req_ready  out M     one-hot accept (zero when nothing is accepted)
//   out_valid  out 1     output register holds a result
//   out_data   out N     unsigned magnitude
//   out_id     out IDW   requester index of out_data
//   out_sat    out 1     sample was the most negative value
//   out_ready  in  1     consumer takes the output this cycle
// ---------------------------------------------------------------------------
module absval_rr_arb
    import absval_pkg::*;
#(
    parameter  int N   = N_DEF,
    parameter  int M   = M_DEF,
    localparam int IDW = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     req_valid,
    input  logic [M*N-1:0]   req_data,
    output logic [M-1:0]     req_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic [IDW-1:0]   out_id,
    output logic             out_sat,
    input  logic             out_ready
);

    logic [IDW-1:0]          ptr;
    logic [M-1:0]            grant_p0;
    logic [IDW-1:0]          idx_p0;
    logic                    any_p0;
    logic                    can_load;
    logic                    accept_p0;
    logic signed [N-1:0]     samp_p0;
    logic [ABS_MAX_W:0]      abs_p0;
    logic [IDW-1:0]          ptr_nxt;

    rr_pick #(.M(M)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant_p0),
        .idx   (idx_p0),
        .any   (any_p0)
    );

    // Stage p0: grant and magnitude, all combinational
    assign can_load  = ~out_valid | out_ready;
    assign accept_p0 = can_load & any_p0 & ~rst;
    // rst gating keeps req_ready low while reset holds the register empty.
    assign req_ready = accept_p0 ? grant_p0 : '0;
    assign samp_p0   = req_data[idx_p0*N +: N];
    assign abs_p0    = abs_sat(ABS_MAX_W'(samp_p0), N);
    assign ptr_nxt   = (idx_p0 == IDW'(M - 1)) ? '0 : idx_p0 + 1'b1;

    // Stage p1: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_sat   <= 1'b0;
            ptr       <= '0;
        end else if (accept_p0) begin
            out_valid <= 1'b1;
            out_data  <= abs_p0[N-1:0];
            out_id    <= idx_p0;
            out_sat   <= abs_p0[ABS_MAX_W];
            ptr       <= ptr_nxt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/absval_rr_arb.md
# absval_rr_arb

Round-robin arbiter that shares one N-bit two's-complement absolute-value unit among M requesters. Each requester presents a signed sample with a valid/ready handshake. The block grants one requester per cycle, computes the saturated magnitude, and holds the result in a single output register tagged with the requester index. It sits between the per-channel front ends and the downstream magnitude consumer, so each channel does not need its own absval instance.

## Interface
- N, 8: sample width, signed two's complement, N ≥ 2
- M, 4: number of requesters, 2 ≤ M ≤ 16
- IDW, $clog2(M): width of the requester index (derived; do not override)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  M  bit i: requester i presents a sample
- req_data  in  M*N  sample of requester i at bits [i*N +: N]
- req_ready  out  M  one-hot or zero; bit i high means requester i is accepted this cycle
- out_valid  out  1  output register holds a result
- out_data  out  N  magnitude, unsigned, range 0..2^(N-1)-1
- out_id  out  IDW  index of the requester that produced out_data
- out_sat  out  1  input was -2^(N-1) and the result was saturated
- out_ready  in  1  consumer accepts the output this cycle

## Operation
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = ~out_valid | out_ready.
- Grant selection (combinational):
  - Search requesters ptr, ptr+1, …, ptr+M-1 (mod M).
  - The first requester with req_valid=1 wins.
  - req_ready[winner] = can_load. All other req_ready bits are 0.
- Accept = can_load & any req_valid. On accept:
  - out_data <= |req_data[winner]|
  - out_id <= winner
  - out_sat <= (sample == -2^(N-1))
  - out_valid <= 1
  - ptr <= (winner+1) mod M. Wrap M-1 → 0 is required for non-power-of-two M.
- Drain without a new accept (out_valid & out_ready & no req_valid): out_valid <= 0. out_data, out_id and out_sat hold their values.
- No accept and no drain: all state holds. ptr changes only on accept.
- Magnitude rule:
  - Non-negative input passes through unchanged.
  - Negative input becomes its two's complement negation.
  - -2^(N-1) becomes 2^(N-1)-1 with out_sat=1.
- Requesters must hold req_valid and req_data stable until req_ready. Dropping a request is allowed. The arbiter must not assume stability and does not check for it.

## Timing
- Reset values: out_valid=0, out_data=0, out_id=0, out_sat=0, ptr=0. req_ready=0 while rst is high.
- Latency: 1 cycle from accept edge to out_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one, out_valid stays 1, and no bubble is inserted.
- Backpressure: while FULL & ~out_ready, all req_ready=0 and the output holds stable.
- Fairness: with all M requesters continuously valid, the grant order is 0,1,…,M-1,0,…. Every requester waits at most M-1 accepts.
- rst asserted mid-operation: state clears immediately (asynchronous). A pending result is discarded. The first grant after release starts at requester 0.
- Combinational paths: req_valid→req_ready and out_ready→req_ready exist. There is no combinational path from input to out_*.

## Structure
- Shared package absval_pkg:
  - localparam defaults for N and M
  - function abs_sat(N-bit) returning {sat, magnitude}, reused by other magnitude consumers
- Sub-module rr_pick (M-bit request vector plus ptr → one-hot grant and encoded index). It is natural to split out and reusable by other arbiters.
- Top level holds ptr, the output register, and the abs_sat call.

## Test plan
- Single request: N=8, only req 2 valid with 0x F9 (-7), out_ready=1 → next cycle out_valid=1, out_data=7, out_id=2, out_sat=0. ptr becomes 3.
- Saturation: req 0 sends 0x80 → out_data=0x7F, out_sat=1. Req 1 then sends 0x81 → out_data=0x7F, out_sat=0.
- Round-robin: all 4 valid continuously with data 1,2,3,4, out_ready=1 → out_id sequence 0,1,2,3,0 and out_data 1,2,3,4,1, one result per cycle.
- Backpressure: out_ready=0 for 5 cycles while FULL → req_ready=0 throughout and out_data/out_id stable. On out_ready=1, drain and accept occur in the same cycle with out_valid staying 1.
- Skip and wrap: ptr=3, only req 1 valid → grant 1 and ptr becomes 2. With M=3, a grant to 2 gives ptr=0.
- Reset mid-stream: assert rst while out_valid=1 and ptr=2 → out_valid drops without waiting for a clock edge. After release with all requests valid, the first out_id is 0.
